fxyz_sweep_ctrl: RTL



---
 rtl/fxyz_pkg.sv | 16 +
 rtl/settle_counter.sv | 26 ++
 rtl/fxyz_sweep_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/fxyz_pkg.sv
// Shared definitions for the fxyz sweep sequencer: state encoding and vector constants.
package fxyz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;

  // Golden truth table for s1 = s2 = ~x | y, bit i = vector {x,y,z}.
  localparam logic [7:0] EXP_TT = 8'hCF;

endpackage

// File: rtl/settle_counter.sv
// Up-counter that measures a fixed settle window; expire is high in the last cycle of the window.
module settle_counter #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(SETTLE) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == W'(SETTLE - 1));

endmodule

// File: rtl/fxyz_sweep_ctrl.sv
// Hardware sweep of one fxyz instance over all 8 input vectors, recording s1/s2 truth tables.
module fxyz_sweep_ctrl
  import fxyz_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s1,
  input  logic       s2,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_s1,
  output logic [7:0] tt_s2,
  output logic [7:0] mismatch,
  output logic       equal
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

  state_t     state, state_nx;
  logic [2:0] idx;
  logic       cnt_load, cnt_en, cnt_expire;
  logic [7:0] mismatch_nx;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .enable (cnt_en),
    .expire (cnt_expire)
  );

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = DRIVE;
          cnt_load = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_expire) begin
          state_nx = SAMPLE;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SAMPLE: begin
        cnt_load = 1'b1;
        state_nx = (idx == LAST_IDX) ? DONE : DRIVE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mismatch_nx      = mismatch;
    mismatch_nx[idx] = s1 ^ s2;
  end

  // busy/done are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt_s1    <= '0;
      tt_s2    <= '0;
      mismatch <= '0;
      equal    <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == DRIVE) || (state_nx == SAMPLE);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            tt_s1    <= '0;
            tt_s2    <= '0;
            mismatch <= '0;
            equal    <= 1'b0;
          end
        end
        SAMPLE: begin
          tt_s1[idx] <= s1;
          tt_s2[idx] <= s2;
          mismatch   <= mismatch_nx;
          if (idx == LAST_IDX) begin
            equal <= (mismatch_nx == '0);
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  assign {x, y, z} = idx;

endmodule
